// File: rtl/adc_acq_scheduler_if.sv
// Control/status bundle between the CSR block and adc_acq_scheduler.
// The master side drives the i_* controls; the slave (the scheduler) drives the o_* pulses and status.
interface adc_acq_scheduler_if #(
    parameter int DIV_WIDTH       = 16,
    parameter int BURST_WIDTH     = 24,
    parameter int TS_PERIOD_WIDTH = 16,
    parameter int OVR_WIDTH       = 16
);
    logic                       i_start;
    logic                       i_stop;
    logic [DIV_WIDTH-1:0]       i_div;
    logic [BURST_WIDTH-1:0]     i_burst_len;
    logic [TS_PERIOD_WIDTH-1:0] i_ts_period;
    logic                       i_adc_ready;
    logic                       i_pps;
    logic                       o_sync_acq;
    logic                       o_sync_ts;
    logic                       o_busy;
    logic                       o_done;
    logic [OVR_WIDTH-1:0]       o_overrun_cnt;

    modport master (
        output i_start, i_stop, i_div, i_burst_len, i_ts_period, i_adc_ready, i_pps,
        input  o_sync_acq, o_sync_ts, o_busy, o_done, o_overrun_cnt
    );

    modport slave (
        input  i_start, i_stop, i_div, i_burst_len, i_ts_period, i_adc_ready, i_pps,
        output o_sync_acq, o_sync_ts, o_busy, o_done, o_overrun_cnt
    );
endinterface

// File: rtl/adc_acq_scheduler.sv
// Acquisition scheduler: sync_acq/sync_ts pulses on a programmable slot grid, bursts, TS tagging,
// overrun counting. Optional PPS alignment of the first slot and TS tags: ADC_SCHED_PPS_ALIGN_EN.
module adc_acq_scheduler #(
    parameter int DIV_WIDTH       = 16,
    parameter int BURST_WIDTH     = 24,
    parameter int TS_PERIOD_WIDTH = 16,
    parameter int OVR_WIDTH       = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    adc_acq_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_FIN      = 2'd2
`ifdef ADC_SCHED_PPS_ALIGN_EN
        , ST_WAIT_PPS = 2'd3
`endif
    } state_t;

    state_t                     r_state, w_state_next;
    logic [DIV_WIDTH-1:0]       r_div, w_div_next;
    logic [DIV_WIDTH-1:0]       r_phase, w_phase_next;
    logic [BURST_WIDTH-1:0]     r_burst, w_burst_next;
    logic [BURST_WIDTH-1:0]     r_slot, w_slot_next, w_k;
    logic [TS_PERIOD_WIDTH-1:0] r_tsp, w_tsp_next;
    logic [TS_PERIOD_WIDTH-1:0] r_ts_cnt, w_ts_cnt_next, w_ts_cur, w_ts_inc;
    logic                       r_ts_pend, w_ts_pend_next;
    logic [OVR_WIDTH-1:0]       r_ovr, w_ovr_next;
    logic                       r_acq, r_ts, r_busy, r_done;
    logic                       w_acq_next, w_ts_next, w_done_next;
    logic                       w_fire, w_first, w_due;

`ifndef ADC_SCHED_PPS_ALIGN_EN
    logic w_unused_pps;
    assign w_unused_pps = bus.i_pps;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_div     <= '0;
            r_phase   <= '0;
            r_burst   <= '0;
            r_slot    <= '0;
            r_tsp     <= '0;
            r_ts_cnt  <= '0;
            r_ts_pend <= 1'b0;
            r_ovr     <= '0;
            r_acq     <= 1'b0;
            r_ts      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_div     <= w_div_next;
            r_phase   <= w_phase_next;
            r_burst   <= w_burst_next;
            r_slot    <= w_slot_next;
            r_tsp     <= w_tsp_next;
            r_ts_cnt  <= w_ts_cnt_next;
            r_ts_pend <= w_ts_pend_next;
            r_ovr     <= w_ovr_next;
            r_acq     <= w_acq_next;
            r_ts      <= w_ts_next;
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= w_done_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_div_next     = r_div;
        w_phase_next   = r_phase;
        w_burst_next   = r_burst;
        w_slot_next    = r_slot;
        w_tsp_next     = r_tsp;
        w_ts_cnt_next  = r_ts_cnt;
        w_ts_pend_next = r_ts_pend;
        w_ovr_next     = r_ovr;
        w_acq_next     = 1'b0;
        w_ts_next      = 1'b0;
        w_done_next    = 1'b0;
        w_fire         = 1'b0;
        w_first        = 1'b0;
        w_due          = 1'b0;
        w_k            = '0;
        w_ts_cur       = '0;
        w_ts_inc       = '0;

        case (r_state)
            ST_IDLE: begin
                // Stop wins over a simultaneous start.
                if (bus.i_start && !bus.i_stop) begin
                    w_div_next     = bus.i_div;
                    w_burst_next   = bus.i_burst_len;
                    w_tsp_next     = bus.i_ts_period;
                    w_ovr_next     = '0;
                    w_ts_pend_next = 1'b0;
`ifdef ADC_SCHED_PPS_ALIGN_EN
                    w_state_next   = ST_WAIT_PPS;
`else
                    w_state_next   = ST_RUN;
                    w_fire         = 1'b1;
                    w_first        = 1'b1;
`endif
                end
            end
`ifdef ADC_SCHED_PPS_ALIGN_EN
            ST_WAIT_PPS: begin
                if (bus.i_stop) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else if (bus.i_pps) begin
                    w_state_next = ST_RUN;
                    w_fire       = 1'b1;
                    w_first      = 1'b1;
                end
            end
`endif
            ST_RUN: begin
                if (bus.i_stop) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end else if (r_phase == '0) begin
                    w_fire = 1'b1;
                end else begin
                    w_phase_next = r_phase - DIV_WIDTH'(1);
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
                w_done_next  = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Slot processing; a skipped slot still advances the grid and the TS schedule.
        if (w_fire) begin
            w_k           = w_first ? '0 : r_slot;
            w_ts_cur      = w_first ? '0 : r_ts_cnt;
            w_ts_inc      = w_ts_cur + TS_PERIOD_WIDTH'(1);
            w_due         = (w_k == '0) || ((w_tsp_next != '0) && (w_ts_cur == '0)) || w_ts_pend_next;
            w_phase_next  = w_div_next;
            w_slot_next   = w_k + BURST_WIDTH'(1);
            w_ts_cnt_next = (w_ts_inc == w_tsp_next) ? '0 : w_ts_inc;
            if (bus.i_adc_ready) begin
                w_acq_next     = 1'b1;
                w_ts_next      = w_due;
                w_ts_pend_next = 1'b0;
            end else begin
                w_ts_pend_next = w_due;
                if (w_ovr_next != '1) begin
                    w_ovr_next = w_ovr_next + OVR_WIDTH'(1);
                end
            end
            if ((w_burst_next != '0) && (w_k == w_burst_next - BURST_WIDTH'(1))) begin
                w_state_next = ST_FIN;
            end
        end

`ifdef ADC_SCHED_PPS_ALIGN_EN
        // A PPS in RUN tags the next issued slot (not one issued in the same cycle).
        if ((r_state == ST_RUN) && !bus.i_stop && bus.i_pps) begin
            w_ts_pend_next = 1'b1;
        end
`endif
    end

    assign bus.o_sync_acq    = r_acq;
    assign bus.o_sync_ts     = r_ts;
    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
    assign bus.o_overrun_cnt = r_ovr;
endmodule

// File: tb/tb_adc_acq_scheduler.sv
// Directed, table-driven bench for adc_acq_scheduler plus hand-written reset and saturation sequences.
module tb_adc_acq_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adc_acq_scheduler_if bus_if ();
    adc_acq_scheduler dut (.i_clk(clk), .i_rst(rst), .bus(bus_if));

    typedef struct {
        logic        start, stop, ready, pps;
        logic [15:0] div;
        logic [23:0] burst;
        logic [15:0] tsp;
        int          reps;
        logic        acq, ts, busy, done;
        logic [15:0] ovr;
        int          tag;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input int st, sp, rd, pp, dv, bl, tp, rp, ea, et, eb, ed, eo, tg);
        vec_t v;
        v.start = st[0];  v.stop = sp[0];  v.ready = rd[0];  v.pps = pp[0];
        v.div   = dv[15:0]; v.burst = bl[23:0]; v.tsp = tp[15:0];
        v.reps  = rp;
        v.acq   = ea[0];  v.ts = et[0];  v.busy = eb[0];  v.done = ed[0];
        v.ovr   = eo[15:0];
        v.tag   = tg;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus_if.i_start     = v.start;
        bus_if.i_stop      = v.stop;
        bus_if.i_adc_ready = v.ready;
        bus_if.i_pps       = v.pps;
        bus_if.i_div       = v.div;
        bus_if.i_burst_len = v.burst;
        bus_if.i_ts_period = v.tsp;
    endtask

    task automatic check_out(input string name, input logic [19:0] exp);
        logic [19:0] act;
        act = {bus_if.o_sync_acq, bus_if.o_sync_ts, bus_if.o_busy, bus_if.o_done, bus_if.o_overrun_cnt};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s acq/ts/busy/done/ovr actual=%b/%b/%b/%b/%h required=%b/%b/%b/%b/%h",
                     name, act[19], act[18], act[17], act[16], act[15:0],
                     exp[19], exp[18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        int acq_seen;
        vec_t idle_v;
        idle_v = mk(0,0,1,0, 0,0,0, 1, 0,0,0,0,0, 0);

`ifdef ADC_SCHED_PPS_ALIGN_EN
        // T6: start waits for PPS; first slot right after PPS; a PPS in RUN tags the next slot.
        tbl.push_back(mk(1,0,1,0, 9,0,0,  1, 0,0,1,0,0, 6));
        tbl.push_back(mk(0,0,1,0, 9,0,0, 49, 0,0,1,0,0, 6));
        tbl.push_back(mk(0,0,1,1, 9,0,0,  1, 1,1,1,0,0, 6));
        tbl.push_back(mk(0,0,1,1, 9,0,0,  1, 0,0,1,0,0, 6));
        tbl.push_back(mk(0,0,1,0, 9,0,0,  8, 0,0,1,0,0, 6));
        tbl.push_back(mk(0,0,1,0, 9,0,0,  1, 1,1,1,0,0, 6));
        tbl.push_back(mk(0,0,1,0, 9,0,0,  9, 0,0,1,0,0, 6));
        tbl.push_back(mk(0,0,1,0, 9,0,0,  1, 1,0,1,0,0, 6));
        tbl.push_back(mk(0,1,1,0, 9,0,0,  1, 0,0,0,1,0, 6));
        tbl.push_back(mk(0,0,1,0, 9,0,0,  2, 0,0,0,0,0, 6));
`else
        // T1: div=9 burst=4, config inputs changed after start must be ignored, pps ignored.
        tbl.push_back(mk(1,0,1,0, 9,4,0, 1, 1,1,1,0,0, 1));
        tbl.push_back(mk(0,0,1,0, 0,7,3, 9, 0,0,1,0,0, 1));
        tbl.push_back(mk(0,0,1,0, 0,7,3, 1, 1,0,1,0,0, 1));
        tbl.push_back(mk(0,0,1,1, 0,7,3, 9, 0,0,1,0,0, 1));
        tbl.push_back(mk(0,0,1,0, 0,7,3, 1, 1,0,1,0,0, 1));
        tbl.push_back(mk(0,0,1,0, 0,7,3, 9, 0,0,1,0,0, 1));
        tbl.push_back(mk(0,0,1,0, 0,7,3, 1, 1,0,1,0,0, 1));
        tbl.push_back(mk(0,0,1,0, 0,7,3, 1, 0,0,0,1,0, 1));
        tbl.push_back(mk(0,0,1,0, 0,7,3, 2, 0,0,0,0,0, 1));
        // T3: div=1 burst=6, ready low over slots 2-3.
        tbl.push_back(mk(1,0,1,0, 1,6,0, 1, 1,1,1,0,0, 3));
        tbl.push_back(mk(0,0,1,0, 1,6,0, 1, 0,0,1,0,0, 3));
        tbl.push_back(mk(0,0,1,0, 1,6,0, 1, 1,0,1,0,0, 3));
        tbl.push_back(mk(0,0,0,0, 1,6,0, 1, 0,0,1,0,0, 3));
        tbl.push_back(mk(0,0,0,0, 1,6,0, 1, 0,0,1,0,1, 3));
        tbl.push_back(mk(0,0,0,0, 1,6,0, 1, 0,0,1,0,1, 3));
        tbl.push_back(mk(0,0,0,0, 1,6,0, 1, 0,0,1,0,2, 3));
        tbl.push_back(mk(0,0,1,0, 1,6,0, 1, 0,0,1,0,2, 3));
        tbl.push_back(mk(0,0,1,0, 1,6,0, 1, 1,0,1,0,2, 3));
        tbl.push_back(mk(0,0,1,0, 1,6,0, 1, 0,0,1,0,2, 3));
        tbl.push_back(mk(0,0,1,0, 1,6,0, 1, 1,0,1,0,2, 3));
        tbl.push_back(mk(0,0,1,0, 1,6,0, 1, 0,0,0,1,2, 3));
        tbl.push_back(mk(0,0,1,0, 1,6,0, 1, 0,0,0,0,2, 3));
        // T4: div=0 burst=5 ts_period=2, slot 2 skipped -> TS deferred to slot 3.
        tbl.push_back(mk(1,0,1,0, 0,5,2, 1, 1,1,1,0,0, 4));
        tbl.push_back(mk(0,0,1,0, 0,5,2, 1, 1,0,1,0,0, 4));
        tbl.push_back(mk(0,0,0,0, 0,5,2, 1, 0,0,1,0,1, 4));
        tbl.push_back(mk(0,0,1,0, 0,5,2, 1, 1,1,1,0,1, 4));
        tbl.push_back(mk(0,0,1,0, 0,5,2, 1, 1,1,1,0,1, 4));
        tbl.push_back(mk(0,0,1,0, 0,5,2, 1, 0,0,0,1,1, 4));
        tbl.push_back(mk(0,0,1,0, 0,5,2, 1, 0,0,0,0,1, 4));
        // T2: div=3 continuous ts_period=2; start while busy ignored; stop mid-run.
        tbl.push_back(mk(1,0,1,0, 3,0,2, 1, 1,1,1,0,0, 2));
        tbl.push_back(mk(0,0,1,0, 3,0,2, 3, 0,0,1,0,0, 2));
        tbl.push_back(mk(0,0,1,0, 3,0,2, 1, 1,0,1,0,0, 2));
        tbl.push_back(mk(1,0,1,0, 0,9,0, 3, 0,0,1,0,0, 2));
        tbl.push_back(mk(0,0,1,0, 0,9,0, 1, 1,1,1,0,0, 2));
        tbl.push_back(mk(0,0,1,0, 0,9,0, 3, 0,0,1,0,0, 2));
        tbl.push_back(mk(0,0,1,0, 0,9,0, 1, 1,0,1,0,0, 2));
        tbl.push_back(mk(0,0,1,0, 0,9,0, 3, 0,0,1,0,0, 2));
        tbl.push_back(mk(0,0,1,0, 0,9,0, 1, 1,1,1,0,0, 2));
        tbl.push_back(mk(0,0,1,0, 0,9,0, 1, 0,0,1,0,0, 2));
        tbl.push_back(mk(0,1,1,0, 0,9,0, 1, 0,0,0,1,0, 2));
        tbl.push_back(mk(0,0,1,0, 0,9,0, 2, 0,0,0,0,0, 2));
        // Stop landing on a slot cycle: no pulse.
        tbl.push_back(mk(1,0,1,0, 0,0,0, 1, 1,1,1,0,0, 7));
        tbl.push_back(mk(0,0,1,0, 0,0,0, 1, 1,0,1,0,0, 7));
        tbl.push_back(mk(0,1,1,0, 0,0,0, 1, 0,0,0,1,0, 7));
        tbl.push_back(mk(0,0,1,0, 0,0,0, 2, 0,0,0,0,0, 7));
        // T5: start+stop together in IDLE, lone stop in IDLE.
        tbl.push_back(mk(1,1,1,0, 2,3,0, 1, 0,0,0,0,0, 5));
        tbl.push_back(mk(0,1,1,0, 2,3,0, 1, 0,0,0,0,0, 5));
        tbl.push_back(mk(0,0,1,0, 2,3,0, 2, 0,0,0,0,0, 5));
        // Burst of one slot.
        tbl.push_back(mk(1,0,1,0, 5,1,3, 1, 1,1,1,0,0, 8));
        tbl.push_back(mk(0,0,1,0, 5,1,3, 1, 0,0,0,1,0, 8));
        tbl.push_back(mk(0,0,1,0, 5,1,3, 2, 0,0,0,0,0, 8));
`endif

        drive(idle_v);
        rst = 1'b1;
        repeat (3) tick();
        check_out("reset_hold", 20'h0);
        rst = 1'b0;
        tick();
        check_out("reset_release", 20'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            int fail_before;
            fail_before = failures;
            drive(tbl[i]);
            for (int r = 0; r < tbl[i].reps; r++) begin
                tick();
                check_out($sformatf("vec%0d_tag%0d_rep%0d", i, tbl[i].tag, r),
                          {tbl[i].acq, tbl[i].ts, tbl[i].busy, tbl[i].done, tbl[i].ovr});
            end
            $display("vec %0d tag=%0d reps=%0d new_errors=%0d", i, tbl[i].tag, tbl[i].reps,
                     failures - fail_before);
        end

`ifndef ADC_SCHED_PPS_ALIGN_EN
        // Reset mid-burst: immediate return to reset state, no done afterwards.
        drive(mk(1,0,1,0, 2,10,0, 1, 0,0,0,0,0, 9));
        tick();
        check_out("rst_mid_first_slot", {1'b1, 1'b1, 1'b1, 1'b0, 16'h0});
        drive(idle_v);
        tick();
        rst = 1'b1;
        tick();
        check_out("rst_mid_applied", 20'h0);
        rst = 1'b0;
        acq_seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            acq_seen += int'(bus_if.o_done) + int'(bus_if.o_busy) + int'(bus_if.o_sync_acq);
        end
        check_val("rst_mid_no_done_busy_acq", acq_seen, 0);
        $display("seq reset_mid_burst done");

        // Every slot skipped from slot 0: overrun saturates, first issued slot carries the deferred TS.
        drive(mk(1,0,0,0, 0,0,0, 1, 0,0,0,0,0, 10));
        tick();
        check_out("sat_first_skip", {1'b0, 1'b0, 1'b1, 1'b0, 16'h0001});
        bus_if.i_start = 1'b0;
        acq_seen = 0;
        for (int c = 0; c < 65540; c++) begin
            tick();
            acq_seen += int'(bus_if.o_sync_acq) + int'(bus_if.o_sync_ts);
        end
        check_val("sat_no_pulses", acq_seen, 0);
        check_out("sat_value", {1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF});
        bus_if.i_adc_ready = 1'b1;
        tick();
        check_out("sat_deferred_ts", {1'b1, 1'b1, 1'b1, 1'b0, 16'hFFFF});
        tick();
        check_out("sat_next_no_ts", {1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF});
        bus_if.i_stop = 1'b1;
        tick();
        check_out("sat_stop_done", {1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF});
        bus_if.i_stop = 1'b0;
        tick();
        check_out("sat_idle", {1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF});
        $display("seq overrun_saturation done");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
